// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM encoding for the 8-way round-robin mux arbiter.
// Pure declarations; no logic, no latency, no flow control.
package mux_arb_pkg;
  localparam int N            = 8;
  localparam int SELW         = 3;
  localparam int HOLD_MAX_DEF = 4;
  localparam int CNTW         = 4;  // covers HOLD_MAX up to 15

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// rr_pick8: combinational rotating-priority search over 8 requests starting at ptr.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[ptr + SELW'(k)]) begin
        found = 1'b1;
        idx   = ptr + SELW'(k);
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving a shared 8:1 mux; grant 1 cycle after request in IDLE, one IDLE gap per release.
// Optional MUX_ARB_LOCK_EN adds a lock input that suspends the hold limit; y is combinational from din.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  input  logic [N-1:0]    din,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            y
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic            lock
`endif
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_MAX - 1);

  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_ptr, w_ptr_nxt;
  logic [SELW-1:0] r_sel, w_sel_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0]    r_gnt, w_gnt_nxt;

  logic            w_found;
  logic [SELW-1:0] w_idx;
  logic            w_lock;
  logic            w_limit;
  logic            w_release;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_limit   = (r_cnt == CNT_LAST) && !w_lock;
  assign w_release = done || !req[r_sel] || w_limit;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = N'(1) << w_idx;
          w_sel_nxt   = w_idx;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel + SELW'(1);
        end else if (!w_lock && (r_cnt != CNT_LAST)) begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = (r_state == GRANT);
  assign y    = busy & din[r_sel];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a cycle-level reference model pushes expected outputs,
// a monitor pops and compares them one step after each rising edge.
module tb_mux8_rr_arbiter;
  localparam int HOLD = 4;

  logic       clk  = 1'b1;
  logic       rst  = 1'b1;
  logic [7:0] req  = 8'h00;
  logic       done = 1'b0;
  logic [7:0] din  = 8'h00;
  logic       lock = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       y;

  mux8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .done (done),
    .din  (din),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .y    (y)
`ifdef MUX_ARB_LOCK_EN
    ,
    .lock (lock)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner is the granted requester or -1, held counts completed GRANT cycles.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_sel   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] di, input logic lk);
    exp_t e;
    logic lk_eff;
    @(negedge clk);
    rst = r; req = rq; done = d; din = di; lock = lk;
`ifdef MUX_ARB_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 1'b0;
`endif
    if (r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (rq[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_sel   = m_owner;
          m_held  = 0;
          break;
        end
      end
    end else begin
      if (d || !rq[m_owner] || (m_held == HOLD - 1 && !lk_eff)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (!lk_eff && m_held < HOLD - 1) begin
        m_held++;
      end
    end
    e.gnt  = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    e.sel  = 3'(m_sel);
    e.busy = (m_owner >= 0);
    e.y    = e.busy ? di[m_sel] : 1'b0;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("gnt",  32'(gnt),  32'(e.gnt));
        chk("sel",  32'(sel),  32'(e.sel));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("y",    32'(y),    32'(e.y));
      end
    end
  end

  logic       t_r;
  logic [7:0] t_rq;
  logic       t_d;
  logic       t_lk;

  initial begin
    // Reset held with all requests asserted, then full rotation
    step(1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0);
    repeat (45) step(1'b0, 8'hFF, 1'b0, 8'($urandom), 1'b0);

    // Grant to 5 leaves ptr at 6; sparse request must wrap to 0, then 2
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (5)  step(1'b0, 8'h20, 1'b0, 8'($urandom), 1'b0);
    repeat (12) step(1'b0, 8'h05, 1'b0, 8'($urandom), 1'b0);

    // Early release by done, then by dropping the request
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h08, 1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b1, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h08, 1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h08, 1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'hFF, 1'b0);

    // Data path through requester 5, then idle with all-ones data
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h20, 1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 8'hFF, 1'b0);

`ifdef MUX_ARB_LOCK_EN
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (15) step(1'b0, 8'h04, 1'b0, 8'($urandom), 1'b1);
    repeat (6)  step(1'b0, 8'h04, 1'b0, 8'($urandom), 1'b0);
`endif

    // Randomized traffic with occasional reset, done and lock
    t_rq = 8'hFF;
    repeat (800) begin
      t_r = ($urandom_range(99) == 0);
      if ($urandom_range(5) == 0)
        t_rq = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'($urandom);
      t_d  = ($urandom_range(7) == 0);
      t_lk = ($urandom_range(3) == 0);
      step(t_r, t_rq, t_d, 8'($urandom), t_lk);
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
